// File: rtl/phase_sequencer.sv
// Five-phase instruction sequencer: one-hot phase strobes, run/stop/halt control, retired-instruction counter.
// Optional single-step mode is compiled in when PHASE_SEQUENCER_SINGLE_STEP_EN is defined.
module phase_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             halt,
    output logic             clockp1,
    output logic             clockp2,
    output logic             clockp3,
    output logic             clockp4,
    output logic             clockp5,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] icount
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_STEP   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       ph_q, ph_d;
    logic             halt_pend_q, halt_pend_d;
    logic             stop_pend_q, stop_pend_d;
    logic [CNT_W-1:0] icount_q, icount_d;
    logic [4:0]       strobe_q, strobe_d;
    logic             running_q, running_d;
    logic             halted_q, halted_d;
    logic             active_d;

`ifndef PHASE_SEQUENCER_SINGLE_STEP_EN
    logic unused_step;
    assign unused_step = step;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        ph_d        = ph_q;
        halt_pend_d = halt_pend_q;
        stop_pend_d = stop_pend_q;
        icount_d    = icount_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_RUN;
                    ph_d    = 3'd0;
                end
`ifdef PHASE_SEQUENCER_SINGLE_STEP_EN
                else if (step && !start) begin
                    state_d = S_STEP;
                    ph_d    = 3'd0;
                end
`endif
            end
            S_RUN, S_STEP: begin
                halt_pend_d = halt_pend_q | halt;
                stop_pend_d = stop_pend_q | (stop && (state_q == S_RUN));
                if (ph_q == 3'd4) begin
                    // Instruction boundary: requests only act here, never mid-instruction.
                    icount_d    = icount_q + CNT_W'(1);
                    ph_d        = 3'd0;
                    halt_pend_d = 1'b0;
                    stop_pend_d = 1'b0;
                    if (halt_pend_q || halt) begin
                        state_d = S_HALTED;
                    end else if ((state_q == S_STEP) || stop_pend_q || stop) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    ph_d = ph_q + 3'd1;
                end
            end
            default: begin
            end
        endcase

        // Strobes are decoded from the next state so they leave a flop cleanly.
        active_d  = (state_d == S_RUN) || (state_d == S_STEP);
        strobe_d  = active_d ? (5'd1 << ph_d) : 5'd0;
        running_d = active_d;
        halted_d  = (state_d == S_HALTED);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ph_q        <= 3'd0;
            halt_pend_q <= 1'b0;
            stop_pend_q <= 1'b0;
            icount_q    <= '0;
            strobe_q    <= 5'd0;
            running_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            ph_q        <= ph_d;
            halt_pend_q <= halt_pend_d;
            stop_pend_q <= stop_pend_d;
            icount_q    <= icount_d;
            strobe_q    <= strobe_d;
            running_q   <= running_d;
            halted_q    <= halted_d;
        end
    end

    assign clockp1 = strobe_q[0];
    assign clockp2 = strobe_q[1];
    assign clockp3 = strobe_q[2];
    assign clockp4 = strobe_q[3];
    assign clockp5 = strobe_q[4];
    assign running = running_q;
    assign halted  = halted_q;
    assign icount  = icount_q;

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Five-phase instruction sequencer for the multi-cycle SIMPLE CPU. It generates the one-hot phase strobes `clockp1`..`clockp5` that step fetch, decode/register-read, execute, memory and writeback. It starts, stops, single-steps and halts the processor, and reacts to the `haltout` flag raised by the decode stage. It also keeps a retired-instruction counter for debug display.

## Interface
Parameters:
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clock` input 1: single system clock; all logic is on its rising edge.
- `reset` input 1: asynchronous, active-low reset. Asserting it clears all state immediately.
- `start` input 1: level, sampled each cycle. Begins free-running execution from IDLE.
- `stop` input 1: level, sampled each cycle. Requests return to IDLE at the next instruction boundary.
- `step` input 1: level, sampled each cycle. Executes exactly one instruction from IDLE (only with `SINGLE_STEP_EN`).
- `halt` input 1: level; connects to the decode stage's `haltout`.
- `clockp1`..`clockp5` output 1 each: phase strobes, registered and one-hot. At most one is high in any cycle.
- `running` output 1: high in RUN and STEP.
- `halted` output 1: high in HALTED.
- `icount` output CNT_W: count of instructions completed (phase 5 finished).

## Operation
- States:
  - IDLE: no strobes.
  - RUN: continuous instructions.
  - STEP: one instruction.
  - HALTED: terminal until reset.
- Phase counter `ph` runs 0..4. While in RUN or STEP, `clockp(ph+1)` is high for one cycle and `ph` advances by 1 modulo 5.
- IDLE -> RUN when `start`=1 and `stop`=0. If both are 1, `stop` wins and the block stays IDLE.
- IDLE -> STEP when `step`=1 and `start`=0 (with `SINGLE_STEP_EN`). If `start` and `step` are both 1, `start` wins.
- Sticky request flags:
  - `halt_pend` is set when `halt`=1 in any cycle of RUN or STEP.
  - `stop_pend` is set when `stop`=1 in any cycle of RUN.
  - Both flags clear on leaving RUN or STEP.
- Instruction boundary is the cycle in which `clockp5` is high. After it:
  - If `halt_pend` or `halt` is 1 -> HALTED.
  - Else if in STEP, or `stop_pend` or `stop` is 1 -> IDLE.
  - Else stay in RUN with `ph`=0.
- Halt has priority over stop when both are pending.
- An instruction is never truncated; `stop` and `halt` take effect only at the boundary.
- HALTED ignores `start`, `stop` and `step`. Only `reset` exits it.
- `icount` increments by 1 at every boundary, including the boundary that enters HALTED. It wraps from 2^CNT_W−1 to 0 without a flag.

## Timing
- Reset values:
  - state=IDLE, `ph`=0, all flags 0.
  - `clockp1`..`clockp5`=0, `running`=0, `halted`=0, `icount`=0.
- Asynchronous assertion takes effect within the same cycle. Deassertion is sampled at the next rising edge.
- Start latency: `start` sampled high at edge t -> `clockp1` and `running` high in the cycle after edge t.
- Strobe pattern: `clockp1` to `clockp5` in five consecutive cycles. `clockp1` of the next instruction follows `clockp5` with no gap.
- One instruction is exactly 5 cycles. Throughput is 1 instruction per 5 cycles.
- `icount` is updated at the same edge that ends the `clockp5` cycle.
- At a terminating boundary, `running` drops and `halted` rises (if halting) at the edge that ends the `clockp5` cycle. No strobe is asserted afterwards.
- Reset mid-instruction: strobes drop immediately. The partial instruction is not counted.

## Configuration
- `PHASE_SEQUENCER_SINGLE_STEP_EN`:
  - Defined: STEP state present; `step` behaves as above.
  - Undefined: STEP state and its logic are removed. `step` is ignored, and IDLE leaves only via `start`.

## Test plan
- Free run: release `reset`, pulse `start` for 1 cycle -> `clockp1`..`clockp5` repeat every 5 cycles. `icount`=4 after 20 strobe cycles; `running`=1.
- Halt: `halt`=1 for one cycle during `clockp3` of instruction 2 -> `clockp4` and `clockp5` still occur. Then `halted`=1, `running`=0, `icount`=2, and no further strobes. `start`=1 afterwards has no effect.
- Stop and simultaneity:
  - `stop` pulsed during `clockp2` -> instruction completes, then IDLE and `icount` increments by 1.
  - `start`=`stop`=1 in IDLE -> remains IDLE.
  - `halt` and `stop` in the same instruction -> HALTED.
- Single step (macro defined): `step` pulsed in IDLE -> exactly 5 strobes, then IDLE, `icount` 0->1. With the macro undefined, the same stimulus produces no strobes and `icount` stays 0.
- Wrap, `CNT_W`=4: run 16 instructions -> `icount` reads 15 after the 15th instruction, then 0 after the 16th; strobes continue uninterrupted.
- Reset mid-operation: assert `reset` during `clockp3` -> all strobes and `running` go to 0 immediately and `icount`=0. After release and `start`, sequencing restarts at `clockp1`.
